// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: widths and control-bundle bit positions.
package mips_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int REG_W_DEF   = 5;
   localparam int ALUOP_W_DEF = 4;
   localparam int CNT_W_DEF   = 16;

   // Control bit positions counted from the bit just above the ALUOp field
   localparam int CTRL_ALUOP_LSB = 0;
   localparam int CTRL_BRANCH    = 0;
   localparam int CTRL_REGDST    = 1;
   localparam int CTRL_ALUSRC    = 2;
   localparam int CTRL_MEMTOREG  = 3;
   localparam int CTRL_MEMWRITE  = 4;
   localparam int CTRL_MEMREAD   = 5;
   localparam int CTRL_REGWRITE  = 6;
   localparam int CTRL_EX_BITS   = 7;

   // The ID-side bundle carries UsesRT/UsesRS between ALUOp and Branch
   localparam int CTRL_ID_USESRT = 0;
   localparam int CTRL_ID_USESRS = 1;
   localparam int CTRL_ID_BITS   = 9;

   localparam logic [CTRL_EX_BITS+ALUOP_W_DEF-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection; drives the PC and IF/ID write enables.
module hazard_detect
   import mips_pkg::*;
#(
   parameter int REG_W = REG_W_DEF
) (
   input  logic             i_ex_memread,
   input  logic [REG_W-1:0] i_ex_rt,
   input  logic [REG_W-1:0] i_if_id_rs,
   input  logic [REG_W-1:0] i_if_id_rt,
   input  logic             i_uses_rs,
   input  logic             i_uses_rt,
   input  logic             i_mem_stall,
   output logic             o_load_use,
   output logic             o_pc_write,
   output logic             o_if_id_write
);

   logic w_rs_hit;
   logic w_rt_hit;

   assign w_rs_hit      = i_uses_rs & (i_if_id_rs == i_ex_rt);
   assign w_rt_hit      = i_uses_rt & (i_if_id_rt == i_ex_rt);
   // A load targeting $0 produces nothing to wait for
   assign o_load_use    = i_ex_memread & (i_ex_rt != '0) & (w_rs_hit | w_rt_hit);
   assign o_pc_write    = ~(o_load_use | i_mem_stall);
   assign o_if_id_write = ~(o_load_use | i_mem_stall);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, memory-stall hold and bubble counter.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_W   = REG_W_DEF,
   parameter int ALUOP_W = ALUOP_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DATA_W-1:0]           IF_ID_PC4,
   input  logic [DATA_W-1:0]           ID_RD1,
   input  logic [DATA_W-1:0]           ID_RD2,
   input  logic [DATA_W-1:0]           ID_Imm,
   input  logic [REG_W-1:0]            IF_ID_RS,
   input  logic [REG_W-1:0]            IF_ID_RT,
   input  logic [REG_W-1:0]            IF_ID_RD,
   input  logic [CTRL_ID_BITS+ALUOP_W-1:0] ID_Ctrl,
   input  logic                        Flush,
   input  logic                        MemStall,
   output logic [DATA_W-1:0]           ID_EX_PC4,
   output logic [DATA_W-1:0]           ID_EX_RD1,
   output logic [DATA_W-1:0]           ID_EX_RD2,
   output logic [DATA_W-1:0]           ID_EX_Imm,
   output logic [REG_W-1:0]            ID_EX_RS,
   output logic [REG_W-1:0]            ID_EX_RT,
   output logic [REG_W-1:0]            ID_EX_RD,
   output logic [CTRL_EX_BITS+ALUOP_W-1:0] ID_EX_Ctrl,
   output logic                        PC_Write,
   output logic                        IF_ID_Write,
   output logic [CNT_W-1:0]            BubbleCount
);

   localparam int IDC_W = CTRL_ID_BITS + ALUOP_W;
   localparam int EXC_W = CTRL_EX_BITS + ALUOP_W;

   logic [DATA_W-1:0] r_pc4, r_rd1, r_rd2, r_imm;
   logic [REG_W-1:0]  r_rs, r_rt, r_rd;
   logic [EXC_W-1:0]  r_ctrl;
   logic [CNT_W-1:0]  r_count;
   logic [EXC_W-1:0]  w_ex_ctrl;
   logic              w_load_use;
   logic              w_bubble;

   // Drop UsesRS/UsesRT: they only matter for hazard detection in ID
   assign w_ex_ctrl = {ID_Ctrl[IDC_W-1:ALUOP_W+2], ID_Ctrl[ALUOP_W-1:CTRL_ALUOP_LSB]};
   assign w_bubble  = Flush | w_load_use;

   hazard_detect #(.REG_W(REG_W)) u_hazard (
      .i_ex_memread (r_ctrl[ALUOP_W+CTRL_MEMREAD]),
      .i_ex_rt      (r_rt),
      .i_if_id_rs   (IF_ID_RS),
      .i_if_id_rt   (IF_ID_RT),
      .i_uses_rs    (ID_Ctrl[ALUOP_W+CTRL_ID_USESRS]),
      .i_uses_rt    (ID_Ctrl[ALUOP_W+CTRL_ID_USESRT]),
      .i_mem_stall  (MemStall),
      .o_load_use   (w_load_use),
      .o_pc_write   (PC_Write),
      .o_if_id_write(IF_ID_Write)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc4   <= '0;
         r_rd1   <= '0;
         r_rd2   <= '0;
         r_imm   <= '0;
         r_rs    <= '0;
         r_rt    <= '0;
         r_rd    <= '0;
         r_ctrl  <= '0;
         r_count <= '0;
      end else if (!MemStall) begin
         // Data and specifiers load even on a bubble; only control is cleared
         r_pc4  <= IF_ID_PC4;
         r_rd1  <= ID_RD1;
         r_rd2  <= ID_RD2;
         r_imm  <= ID_Imm;
         r_rs   <= IF_ID_RS;
         r_rt   <= IF_ID_RT;
         r_rd   <= IF_ID_RD;
         r_ctrl <= w_bubble ? '0 : w_ex_ctrl;
         if (w_bubble && (r_count != '1)) r_count <= r_count + 1'b1;
      end
   end

   assign ID_EX_PC4   = r_pc4;
   assign ID_EX_RD1   = r_rd1;
   assign ID_EX_RD2   = r_rd2;
   assign ID_EX_Imm   = r_imm;
   assign ID_EX_RS    = r_rs;
   assign ID_EX_RT    = r_rt;
   assign ID_EX_RD    = r_rd;
   assign ID_EX_Ctrl  = r_ctrl;
   assign BubbleCount = r_count;

endmodule
